// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard and sequencing controller for a 5-stage MIPS pipeline:
//                forwarding selects, load-use stall, branch flush, memory-wait
//                freeze with timeout, and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             store_id,
    input  logic [4:0]       wn_exe,
    input  logic             wreg_exe,
    input  logic             m2reg_exe,
    input  logic [4:0]       wn_mem,
    input  logic             wreg_mem,
    input  logic             m2reg_mem,
    input  logic             branch_taken_id,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    output logic [1:0]       ADEPEN,
    output logic [1:0]       BDEPEN,
    output logic [1:0]       STOREDEPEN,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_en,
    output logic             idexe_bubble,
    output logic             exemem_en,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]  C_TIMEOUT = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    logic [TO_W-1:0]  r_timer;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_err;

    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [1:0]       w_fwd_s;
    logic             w_loaduse;
    logic             w_memfreeze;
    logic             w_freeze;

    // Newest non-load producer wins; a load still in EXE cannot forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       gate,
        input logic [4:0] f_wn_exe,
        input logic       f_wreg_exe,
        input logic       f_m2reg_exe,
        input logic [4:0] f_wn_mem,
        input logic       f_wreg_mem,
        input logic       f_m2reg_mem
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (gate && (src != 5'd0)) begin
            if (f_wreg_exe && !f_m2reg_exe && (f_wn_exe == src)) begin
                sel = 2'b01;
            end else if (f_wreg_mem && (f_wn_mem == src)) begin
                sel = f_m2reg_mem ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(rs_id, use_rs_id, wn_exe, wreg_exe, m2reg_exe,
                          wn_mem, wreg_mem, m2reg_mem);
        w_fwd_b = fwd_sel(rt_id, use_rt_id, wn_exe, wreg_exe, m2reg_exe,
                          wn_mem, wreg_mem, m2reg_mem);
        w_fwd_s = fwd_sel(rt_id, store_id, wn_exe, wreg_exe, m2reg_exe,
                          wn_mem, wreg_mem, m2reg_mem);
    end

    always_comb begin
        w_loaduse = wreg_exe && m2reg_exe && (wn_exe != 5'd0) &&
                    ((use_rs_id && (wn_exe == rs_id)) ||
                     ((use_rt_id || store_id) && (wn_exe == rt_id)));
        w_memfreeze = dmem_req_mem && !dmem_ack;
    end

    // Once waiting, only the acknowledge releases the freeze.
    always_comb begin
        case (r_state)
            ST_RUN:     w_freeze = w_memfreeze;
            ST_MEMWAIT: w_freeze = !dmem_ack;
            default:    w_freeze = 1'b1;
        endcase
    end

    always_comb begin
        ADEPEN       = w_fwd_a;
        BDEPEN       = w_fwd_b;
        STOREDEPEN   = w_fwd_s;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idexe_en     = 1'b1;
        idexe_bubble = 1'b0;
        exemem_en    = 1'b1;
        memwb_bubble = 1'b0;
        if (!Resetn) begin
            ADEPEN       = 2'b00;
            BDEPEN       = 2'b00;
            STOREDEPEN   = 2'b00;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idexe_en     = 1'b0;
            idexe_bubble = 1'b1;
            exemem_en    = 1'b0;
            memwb_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idexe_en     = 1'b0;
            exemem_en    = 1'b0;
            memwb_bubble = 1'b1;
        end else if (w_loaduse) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idexe_bubble = 1'b1;
        end else begin
            ifid_flush   = branch_taken_id;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state     <= ST_RUN;
            r_timer     <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (!pc_en && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_RUN: begin
                    if (w_memfreeze) begin
                        r_state <= ST_MEMWAIT;
                        r_timer <= TO_W'(1);
                    end
                end
                ST_MEMWAIT: begin
                    if (dmem_ack) begin
                        r_state <= ST_RUN;
                        r_timer <= '0;
                    end else if (r_timer == C_TIMEOUT) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TO_W'(1);
                    end
                end
                ST_ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign err       = r_err;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Computes the ADEPEN/BDEPEN/STOREDEPEN forwarding selects for the instruction in ID; these travel down the ID/EXE register.
- Generates enable, bubble and flush controls for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It covers load-use hazards, taken branches, and data-memory wait states.
- Runs a memory-wait timeout FSM and a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 16: width of stall_cnt.
- TO_W, 8: width of the memory-wait timer.
- MEM_TIMEOUT, 200: number of consecutive MEMWAIT cycles without dmem_ack before entering ERR.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- rs_id  in  5  rs field of the ID instruction.
- rt_id  in  5  rt field of the ID instruction.
- use_rs_id  in  1  ID instruction reads rs as ALU operand A.
- use_rt_id  in  1  ID instruction reads rt as ALU operand B.
- store_id  in  1  ID instruction is a store; rt is the store data.
- wn_exe  in  5  destination register in EXE.
- wreg_exe  in  1  EXE instruction writes the register file.
- m2reg_exe  in  1  EXE instruction is a load.
- wn_mem  in  5  destination register in MEM.
- wreg_mem  in  1  MEM instruction writes the register file.
- m2reg_mem  in  1  MEM instruction is a load.
- branch_taken_id  in  1  branch/jump resolved taken in ID.
- dmem_req_mem  in  1  MEM stage is accessing data memory.
- dmem_ack  in  1  data memory completes the access this cycle.
- ADEPEN  out  2  operand A forward select.
- BDEPEN  out  2  operand B forward select.
- STOREDEPEN  out  2  store-data forward select.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idexe_en  out  1  ID/EXE load enable.
- idexe_bubble  out  1  ID/EXE loads zeroed controls (wreg, wmem, m2reg = 0).
- exemem_en  out  1  EXE/MEM load enable.
- memwb_bubble  out  1  MEM/WB loads zeroed controls.
- stall_cnt  out  CNT_W  count of stalled cycles, saturating.
- err  out  1  sticky memory-timeout error.
- state  out  2  FSM state: RUN=0, MEMWAIT=1, ERR=2.

Behaviour:
- Reset (Resetn=0 sampled at a rising edge):
  - state=RUN, wait timer=0, stall_cnt=0, err=0.
  - While Resetn=0, all outputs are forced: every *_en=0, idexe_bubble=1, memwb_bubble=1, ifid_flush=0, all DEPEN=00.
- Forwarding selects (combinational, per operand X in {rs for A, rt for B and STORE}):
  - 00 = register file.
  - 01 = EXE ALU result: wreg_exe & !m2reg_exe & wn_exe==X.
  - 10 = MEM ALU result: wreg_mem & !m2reg_mem & wn_mem==X.
  - 11 = MEM load data: wreg_mem & m2reg_mem & wn_mem==X.
  - EXE match has priority over MEM match.
  - X==0 always gives 00.
  - A is gated by use_rs_id, B by use_rt_id, STORE by store_id; when the gate is low the select is 00.
- Load-use hazard (loaduse): wreg_exe & m2reg_exe & wn_exe!=0 & ((use_rs_id & wn_exe==rs_id) | ((use_rt_id|store_id) & wn_exe==rt_id)).
- memfreeze: dmem_req_mem & !dmem_ack.
- State RUN:
  - If memfreeze: pc_en=ifid_en=idexe_en=exemem_en=0, memwb_bubble=1; next state MEMWAIT; timer is loaded with 1.
  - Else if loaduse: pc_en=0, ifid_en=0, idexe_bubble=1 (idexe_en=1), exemem_en=1. Stays in RUN. The next cycle resolves through select 11.
  - Else: all enables=1, no bubbles. ifid_flush=branch_taken_id.
  - Priority is memfreeze > loaduse > branch. ifid_flush is 0 whenever ifid_en=0.
- State MEMWAIT:
  - While !dmem_ack: full freeze as above and the timer increments.
  - If the timer equals MEM_TIMEOUT while !dmem_ack: next state ERR and err is set.
  - On dmem_ack=1: freeze released that same cycle, outputs follow the RUN rules excluding memfreeze, next state RUN, timer cleared.
- State ERR: full freeze, err=1. The only exit is reset.
- stall_cnt increments by 1 on every cycle with pc_en=0 while Resetn=1. It saturates at all-ones.
- All outputs except stall_cnt, err and state are combinational from inputs and state. A single cycle can be both a load-use stall and a freeze; it is counted once.

Test Plan:
- Forwarding: EXE `add $3` (wreg_exe=1, m2reg_exe=0, wn_exe=3) and MEM `add $3` both present; ID uses rs=3 -> ADEPEN=01. With EXE idle -> ADEPEN=10. With rs=0 and wn_exe=0 -> ADEPEN=00.
- Load-use: EXE `lw $5` (m2reg_exe=1, wn_exe=5); ID `add` with rt=5, use_rt_id=1 -> one cycle of pc_en=0, ifid_en=0, idexe_bubble=1. Next cycle (load now in MEM) -> BDEPEN=11, no stall. stall_cnt=1.
- Store data: ID `sw` with rt=7, store_id=1, use_rt_id=0; MEM `lw $7` -> STOREDEPEN=11, BDEPEN=00.
- Branch: branch_taken_id=1 with no hazard -> ifid_flush=1, pc_en=1. Same with loaduse=1 -> ifid_flush=0, pc_en=0.
- Memory wait: dmem_req_mem=1, dmem_ack=0 for 3 cycles, then ack -> state 0→1→1→1→0. Freeze lasts 3 cycles, enables return in the ack cycle, stall_cnt=3.
- Timeout and reset: with MEM_TIMEOUT=4, no ack -> err=1 and state=2 after the 4th wait cycle, and the freeze holds. Assert Resetn=0 mid-ERR -> next edge gives state=0, err=0, stall_cnt=0.
